// File: rtl/servo_pkg.sv
// Shared definitions for the servo pulse generator and the pulse-width
// measurement block.
//   servo_state_e      : frame engine state encoding (IDLE / RUN / DRAIN)
//   WIDTH_W            : width of counters, commands and pulse widths
//   DEF_PERIOD_CYCLES  : default frame length (20 ms at 50 MHz)
//   DEF_MIN_PULSE      : default minimum high time (1 ms)
//   DEF_MAX_PULSE      : default maximum high time (2 ms)
//   DEF_SLEW_STEP      : default width change per frame (0 = unlimited)
package servo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } servo_state_e;

  localparam int unsigned WIDTH_W           = 32;
  localparam int unsigned DEF_PERIOD_CYCLES = 1000000;
  localparam int unsigned DEF_MIN_PULSE     = 50000;
  localparam int unsigned DEF_MAX_PULSE     = 100000;
  localparam int unsigned DEF_SLEW_STEP     = 0;

endpackage : servo_pkg

// File: rtl/servo_slew_step.sv
// One slew step: moves the current width toward the target by at most
// step_i clocks. step_i == 0 means the target is reached in one step.
//   cur_i  : width currently in use
//   tgt_i  : width being approached
//   step_i : largest allowed change (0 = unlimited)
//   nxt_o  : width for the next frame
// The difference is formed in WIDTH_W+1 bits so any pair of unsigned
// operands is represented without overflow; cur +/- step never passes the
// target because that case takes the "reach target" branch.
module servo_slew_step
  import servo_pkg::*;
(
  input  logic [WIDTH_W-1:0] cur_i,
  input  logic [WIDTH_W-1:0] tgt_i,
  input  logic [WIDTH_W-1:0] step_i,
  output logic [WIDTH_W-1:0] nxt_o
);

  logic signed [WIDTH_W:0] diff;
  logic        [WIDTH_W:0] mag;

  always_comb begin
    diff = $signed({1'b0, tgt_i}) - $signed({1'b0, cur_i});
    mag  = diff[WIDTH_W] ? $unsigned(-diff) : $unsigned(diff);
    if ((step_i == '0) || (mag <= {1'b0, step_i})) begin
      nxt_o = tgt_i;
    end else if (diff[WIDTH_W]) begin
      nxt_o = cur_i - step_i;
    end else begin
      nxt_o = cur_i + step_i;
    end
  end

endmodule : servo_slew_step

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM frame generator.
//   clock_clk    : single clock, rising edge
//   reset_low    : asynchronous active-low reset
//   enable       : request pulse generation
//   cmd_width    : requested pulse width in clocks (clamped to MIN..MAX)
//   cmd_valid    : cmd_width valid
//   cmd_ready    : pending slot empty; accept on cmd_valid && cmd_ready
//   pwm_out      : registered servo drive pulse
//   period_start : one-cycle strobe on frame cycle 0
//   active_width : width used by the current frame
// Width changes only take effect at frame boundaries so a pulse is never
// cut short or stretched mid-frame; in IDLE a command applies at once.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int unsigned MIN_PULSE     = DEF_MIN_PULSE,
  parameter int unsigned MAX_PULSE     = DEF_MAX_PULSE,
  parameter int unsigned SLEW_STEP     = DEF_SLEW_STEP
) (
  input  logic               clock_clk,
  input  logic               reset_low,
  input  logic               enable,
  input  logic [WIDTH_W-1:0] cmd_width,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic               pwm_out,
  output logic               period_start,
  output logic [WIDTH_W-1:0] active_width
);

  if (!((MIN_PULSE <= MAX_PULSE) && (MAX_PULSE < PERIOD_CYCLES))) begin : g_param_check
    $error("servo_pwm_gen: parameters must satisfy MIN_PULSE <= MAX_PULSE < PERIOD_CYCLES");
  end

  localparam logic [WIDTH_W-1:0] MIN_W     = WIDTH_W'(MIN_PULSE);
  localparam logic [WIDTH_W-1:0] MAX_W     = WIDTH_W'(MAX_PULSE);
  localparam logic [WIDTH_W-1:0] STEP_W    = WIDTH_W'(SLEW_STEP);
  localparam logic [WIDTH_W-1:0] LAST_CNT  = WIDTH_W'(PERIOD_CYCLES - 1);
  localparam logic [WIDTH_W-1:0] MID_W     = WIDTH_W'((MIN_PULSE + MAX_PULSE) / 2);

  function automatic logic [WIDTH_W-1:0] clamp_width(input logic [WIDTH_W-1:0] w);
    if (w < MIN_W) return MIN_W;
    if (w > MAX_W) return MAX_W;
    return w;
  endfunction

  servo_state_e       state_q, state_d;
  logic [WIDTH_W-1:0] cnt_q, cnt_d;
  logic [WIDTH_W-1:0] pend_q, pend_d;
  logic               pend_full_q, pend_full_d;
  logic [WIDTH_W-1:0] active_q, active_d;
  logic [WIDTH_W-1:0] target_q, target_d;
  logic               pwm_q, pwm_d;
  logic               pstart_q, pstart_d;

  logic [WIDTH_W-1:0] bnd_tgt;
  logic [WIDTH_W-1:0] slew_nxt;
  logic               wrap;

  // A pending command becomes the target at the boundary; without one the
  // existing target keeps pulling active_width along (multi-frame slew).
  assign bnd_tgt = pend_full_q ? pend_q : target_q;
  assign wrap    = (cnt_q == LAST_CNT);

  servo_slew_step u_slew (
    .cur_i  (active_q),
    .tgt_i  (bnd_tgt),
    .step_i (STEP_W),
    .nxt_o  (slew_nxt)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    active_d    = active_q;
    target_d    = target_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pend_full_q) begin
          active_d    = pend_q;
          target_d    = pend_q;
          pend_full_d = 1'b0;
        end
        if (enable) state_d = ST_RUN;
      end
      ST_RUN, ST_DRAIN: begin
        if (wrap) begin
          // Boundary: uses the pending slot as it stood before this edge,
          // so a command accepted on this same edge waits one more frame.
          cnt_d    = '0;
          active_d = slew_nxt;
          target_d = bnd_tgt;
          if (pend_full_q) pend_full_d = 1'b0;
          state_d  = enable ? ST_RUN : ST_IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = enable ? ST_RUN : ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Acceptance only happens with the slot empty, so it never collides
    // with the clears above.
    if (cmd_valid && !pend_full_q) begin
      pend_d      = clamp_width(cmd_width);
      pend_full_d = 1'b1;
    end

    // Outputs are registered from next-state values so they line up with
    // the counter value of the cycle they belong to.
    pwm_d    = (state_d != ST_IDLE) && (cnt_d < active_d);
    pstart_d = (state_d != ST_IDLE) && (cnt_d == '0);
  end

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      active_q    <= MID_W;
      target_q    <= MID_W;
      pwm_q       <= 1'b0;
      pstart_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      active_q    <= active_d;
      target_q    <= target_d;
      pwm_q       <= pwm_d;
      pstart_q    <= pstart_d;
    end
  end

  assign cmd_ready    = ~pend_full_q;
  assign pwm_out      = pwm_q;
  assign period_start = pstart_q;
  assign active_width = active_q;

endmodule : servo_pwm_gen
